// File: rtl/lsmitll_ndrot_bank_pkg.sv
// Shared types and defaults for the RSFQ NDRO bank abstraction.
package lsmitll_ndrot_bank_pkg;

  typedef enum logic {
    MODE_NDRO = 1'b0,
    MODE_DRO  = 1'b1
  } ndrot_mode_e;

  localparam int unsigned NDROT_N_DEF     = 4;
  localparam int unsigned NDROT_DELAY_DEF = 2;
  localparam int unsigned NDROT_HOLD_DEF  = 3;

  // Width of a counter that must reach HOLD_CYC (at least one bit).
  function automatic int unsigned ndrot_cnt_w(input int unsigned hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/lsmitll_toggle_det.sv
// Toggle-to-pulse detector: one pulse per input transition.
// The last-seen level is loaded every cycle, reset included, so inputs
// held static through reset produce no pulse afterwards.
module lsmitll_toggle_det
  import lsmitll_ndrot_bank_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] tog_i,
  output logic [W-1:0] pulse_o
);

  logic [W-1:0] tog_q;

  // Registered copy of the toggle levels.
  always_ff @(posedge clk_i) begin
    tog_q <= tog_i;
  end

  assign pulse_o = rst_i ? '0 : (tog_i ^ tog_q);

endmodule

// File: rtl/lsmitll_ndrot_bank.sv
// N-channel NDRO/DRO bank with a shared read line and toggle-encoded I/O.
// Optional feature macro: NDROT_BANK_VIOL_EN enables per-channel sticky
// timing-violation flags; without it viol is tied low.
module lsmitll_ndrot_bank
  import lsmitll_ndrot_bank_pkg::*;
#(
  parameter int unsigned N        = NDROT_N_DEF,
  parameter int unsigned DELAY    = NDROT_DELAY_DEF,
  parameter ndrot_mode_e MODE     = MODE_NDRO,
  parameter int unsigned HOLD_CYC = NDROT_HOLD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] set_t,
  input  logic [N-1:0] clr_t,
  input  logic         rd_t,
  output logic [N-1:0] q_t,
  output logic [N-1:0] state_o,
  output logic [N-1:0] viol
);

  if (N < 1 || DELAY < 1 || HOLD_CYC > 65535) begin : g_bad_cfg
    $error("lsmitll_ndrot_bank: invalid parameter set");
  end

  logic [N-1:0] set_p, clr_p;
  logic         rd_p;
  logic [N-1:0] state_q, hit, exit_hit, q_q;

  lsmitll_toggle_det #(.W(N)) u_set_det (
    .clk_i(clk), .rst_i(rst), .tog_i(set_t), .pulse_o(set_p)
  );
  lsmitll_toggle_det #(.W(N)) u_clr_det (
    .clk_i(clk), .rst_i(rst), .tog_i(clr_t), .pulse_o(clr_p)
  );
  lsmitll_toggle_det #(.W(1)) u_rd_det (
    .clk_i(clk), .rst_i(rst), .tog_i(rd_t), .pulse_o(rd_p)
  );

`ifdef NDROT_BANK_VIOL_EN
  localparam int unsigned CNT_W = ndrot_cnt_w(HOLD_CYC);

  logic [CNT_W-1:0] rd_cnt_q;
  logic             rd_live;

  assign rd_live = (rd_cnt_q < CNT_W'(HOLD_CYC));

  // Cycles since the last read pulse, saturating once the window has passed.
  always_ff @(posedge clk) begin
    if (rst)          rd_cnt_q <= CNT_W'(HOLD_CYC);
    else if (rd_p)    rd_cnt_q <= '0;
    else if (rd_live) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
  end
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic st_q, st_d;

    assign hit[i]     = rd_p & st_q;
    assign state_q[i] = st_q;

    // Next stored bit: clear beats set, set beats a destructive read.
    always_comb begin
      st_d = st_q;
      if (clr_p[i])                          st_d = 1'b0;
      else if (set_p[i])                     st_d = 1'b1;
      else if (MODE == MODE_DRO && hit[i])   st_d = 1'b0;
    end

    // Stored bit register.
    always_ff @(posedge clk) begin
      if (rst) st_q <= 1'b0;
      else     st_q <= st_d;
    end

`ifdef NDROT_BANK_VIOL_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_last_q, set_last_d;
    logic             viol_q, viol_d;
    logic             live, bad;

    // Hold-window checks; the counter restarts only on state-changing set/clr.
    always_comb begin
      live = (cnt_q < CNT_W'(HOLD_CYC));
      bad  = (set_p[i] & clr_p[i])
           | (clr_p[i] & ~set_p[i] & set_last_q & live)
           | (set_p[i] & ~clr_p[i] & ~set_last_q & live)
           | (hit[i] & rd_live);
      viol_d     = viol_q | bad;
      cnt_d      = cnt_q;
      set_last_d = set_last_q;
      if (set_p[i] & ~clr_p[i] & ~st_q) begin
        cnt_d      = '0;
        set_last_d = 1'b1;
      end else if (clr_p[i] & ~set_p[i] & st_q) begin
        cnt_d      = '0;
        set_last_d = 1'b0;
      end else if (live) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Violation tracking state; flags stay set until reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q      <= CNT_W'(HOLD_CYC);
        set_last_q <= 1'b0;
        viol_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        set_last_q <= set_last_d;
        viol_q     <= viol_d;
      end
    end

    assign viol[i] = viol_q;
`endif
  end

`ifndef NDROT_BANK_VIOL_EN
  assign viol = '0;
`endif

  // DELAY-1 registers between the hit and the output toggle; DELAY=1 toggles
  // on the same edge the read is processed.
  if (DELAY == 1) begin : g_nopipe
    assign exit_hit = hit;
  end else begin : g_pipe
    logic [N-1:0] pipe_q [DELAY-1];

    // Read-hit shift register; reset discards hits in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_q <= '{default: '0};
      end else begin
        pipe_q[0] <= hit;
        for (int unsigned s = 1; s < DELAY - 1; s++) begin
          pipe_q[s] <= pipe_q[s-1];
        end
      end
    end

    assign exit_hit = pipe_q[DELAY-2];
  end

  // Toggle-encoded output: each hit leaving the pipeline flips q_t.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_q ^ exit_hit;
  end

  assign q_t     = q_q;
  assign state_o = state_q;

endmodule
